// File: rtl/sys_mem2apb_bridge_if.sv
// rtl/sys_mem2apb_bridge_if.sv - system request/response channel and APB4 bus bundles
interface sys_req_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            req_wr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            resp_valid;
  logic            resp_ready;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_addr, req_wr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface apb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/sys_mem2apb_bridge.sv
// rtl/sys_mem2apb_bridge.sv - single-outstanding system bus to APB4 bridge with PREADY timeout
module sys_mem2apb_bridge #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic      clk,
  input  logic      rstn,
  sys_req_if.slave  sys,
  apb_if.master     apb
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // A zero timeout still needs a legal one-bit counter; it is simply never compared.
  localparam int         CW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit         TO_EN    = (TIMEOUT_CYC != 0);
  localparam int         TO_LAST  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [1:0]      state_q, state_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [DW/8-1:0] pstrb_q, pstrb_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Next-state and output-register logic for the four-phase transfer sequence.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (sys.req_valid) begin
          paddr_d  = {sys.req_addr[AW-1:2], 2'b00};
          pwrite_d = sys.req_wr;
          pwdata_d = sys.req_wdata;
          pstrb_d  = sys.req_wr ? sys.req_wstrb : '0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (apb.pready) begin
          resp_rdata_d = (pwrite_q || apb.pslverr) ? '0 : apb.prdata;
          resp_err_d   = apb.pslverr;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
          // Counter starts at 0 in the first ACCESS cycle, so matching
          // TIMEOUT_CYC-1 aborts on the TIMEOUT_CYC-th stalled cycle.
          if (TO_EN && (cnt_q == CNT_LAST)) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end
        end
      end
      RESP: begin
        if (sys.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sys.req_ready  = (state_q == IDLE);
  assign sys.resp_valid = resp_valid_q;
  assign sys.resp_rdata = resp_rdata_q;
  assign sys.resp_err   = resp_err_q;
  assign apb.psel       = psel_q;
  assign apb.penable    = penable_q;
  assign apb.pwrite     = pwrite_q;
  assign apb.paddr      = paddr_q;
  assign apb.pwdata     = pwdata_q;
  assign apb.pstrb      = pstrb_q;
  assign apb.pprot      = 3'b000;

endmodule
